game_sequencer: RTL and testbench

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/game_sequencer.sv | 172 +++++++++++++++++
 tb/tb_game_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// Frogger-style game sequencer: game tick, play/death/level-up FSM and
// per-lane car-move strobes whose period shortens as the level rises.
module game_sequencer #(
    parameter int TICK_DIV      = 1000000,
    parameter int DEATH_TICKS   = 8,
    parameter int LEVELUP_TICKS = 4,
    parameter int START_LIVES   = 3
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic       i_Start,
    input  logic       i_Abort,
    input  logic       i_Collision,
    input  logic       i_Frog_At_Top,
    output logic [2:0] o_State,
    output logic [3:0] o_Level,
    output logic [1:0] o_Lives,
    output logic       o_Reset_Frog,
    output logic [7:0] o_Lane_Step,
    output logic       o_Flash,
    output logic       o_Tick
);

    localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PMAX = (DEATH_TICKS > LEVELUP_TICKS) ? DEATH_TICKS : LEVELUP_TICKS;
    localparam int PW   = $clog2(PMAX + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PLAY      = 3'd1,
        DYING     = 3'd2,
        LEVEL_UP  = 3'd3,
        GAME_OVER = 3'd4
    } state_t;

    state_t          state_reg;
    logic [TW-1:0]   tick_cnt_reg;
    logic            tick_reg;
    logic            start_reg;
    logic [3:0]      level_reg;
    logic [1:0]      lives_reg;
    logic [PW-1:0]   pause_reg;
    logic            flash_reg;
    logic            frog_reg;
    logic [7:0]      step_reg;
    logic [3:0]      lane_cnt_reg [8];

    logic            start_event;
    logic            tick_wrap;
    logic [4:0]      lvl_m1;
    logic [3:0]      period [8];

    assign start_event = i_Start & ~start_reg;
    assign tick_wrap   = (tick_cnt_reg == TW'(TICK_DIV - 1));
    assign lvl_m1      = {1'b0, level_reg} - 5'd1;

    // Lane period = max(2, base - (level-1)); even lanes are the slow ones.
    for (genvar gi = 0; gi < 8; gi++) begin : g_period
        localparam logic [4:0] BASE = (gi % 2 == 0) ? 5'd12 : 5'd9;
        assign period[gi] = (BASE > lvl_m1 + 5'd2) ? 4'(BASE - lvl_m1) : 4'd2;
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state_reg    <= IDLE;
            tick_cnt_reg <= '0;
            tick_reg     <= 1'b0;
            start_reg    <= 1'b1;
            level_reg    <= 4'd1;
            lives_reg    <= 2'(START_LIVES);
            pause_reg    <= '0;
            flash_reg    <= 1'b0;
            frog_reg     <= 1'b1;
            step_reg     <= '0;
            for (int i = 0; i < 8; i++) lane_cnt_reg[i] <= '0;
        end else begin
            start_reg    <= i_Start;
            tick_reg     <= tick_wrap;
            tick_cnt_reg <= tick_wrap ? '0 : tick_cnt_reg + 1'b1;
            frog_reg     <= 1'b0;
            step_reg     <= '0;

            // Frog-reset requests are gated by the current pulse so two never abut.
            if (i_Abort) begin
                state_reg <= IDLE;
                level_reg <= 4'd1;
                lives_reg <= 2'(START_LIVES);
                pause_reg <= '0;
                flash_reg <= 1'b0;
                frog_reg  <= ~frog_reg;
                for (int i = 0; i < 8; i++) lane_cnt_reg[i] <= '0;
            end else begin
                case (state_reg)
                    IDLE, GAME_OVER: begin
                        if (start_event) begin
                            state_reg <= PLAY;
                            level_reg <= 4'd1;
                            lives_reg <= 2'(START_LIVES);
                            frog_reg  <= ~frog_reg;
                            for (int i = 0; i < 8; i++) lane_cnt_reg[i] <= '0;
                        end
                    end
                    PLAY: begin
                        if (i_Collision) begin
                            state_reg <= DYING;
                            lives_reg <= (lives_reg == 2'd0) ? 2'd0 : lives_reg - 2'd1;
                            pause_reg <= '0;
                            flash_reg <= 1'b0;
                        end else if (i_Frog_At_Top) begin
                            state_reg <= LEVEL_UP;
                            level_reg <= (level_reg == 4'd15) ? 4'd15 : level_reg + 4'd1;
                            pause_reg <= '0;
                        end else if (tick_reg) begin
                            // >= lets a counter stranded above a shortened period wrap at once.
                            for (int i = 0; i < 8; i++) begin
                                if (lane_cnt_reg[i] >= period[i] - 4'd1) begin
                                    lane_cnt_reg[i] <= '0;
                                    step_reg[i]     <= 1'b1;
                                end else begin
                                    lane_cnt_reg[i] <= lane_cnt_reg[i] + 4'd1;
                                end
                            end
                        end
                    end
                    DYING: begin
                        if (tick_reg) begin
                            if (pause_reg == PW'(DEATH_TICKS - 1)) begin
                                pause_reg <= '0;
                                flash_reg <= 1'b0;
                                if (lives_reg == 2'd0) begin
                                    state_reg <= GAME_OVER;
                                end else begin
                                    state_reg <= PLAY;
                                    frog_reg  <= ~frog_reg;
                                    for (int i = 0; i < 8; i++) lane_cnt_reg[i] <= '0;
                                end
                            end else begin
                                pause_reg <= pause_reg + 1'b1;
                                flash_reg <= ~flash_reg;
                            end
                        end
                    end
                    LEVEL_UP: begin
                        if (tick_reg) begin
                            if (pause_reg == PW'(LEVELUP_TICKS - 1)) begin
                                pause_reg <= '0;
                                state_reg <= PLAY;
                                frog_reg  <= ~frog_reg;
                                for (int i = 0; i < 8; i++) lane_cnt_reg[i] <= '0;
                            end else begin
                                pause_reg <= pause_reg + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        flash_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_State      = state_reg;
    assign o_Level      = level_reg;
    assign o_Lives      = lives_reg;
    assign o_Reset_Frog = frog_reg;
    assign o_Lane_Step  = step_reg;
    assign o_Flash      = flash_reg;
    assign o_Tick       = tick_reg;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with a fast tick (TICK_DIV=4).
module tb_game_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, start, abort_in, collision, at_top;
    logic [2:0] state;
    logic [3:0] level;
    logic [1:0] lives;
    logic       reset_frog, flash, tick;
    logic [7:0] lane_step;

    always #5 clk = ~clk;

    game_sequencer #(
        .TICK_DIV(4), .DEATH_TICKS(8), .LEVELUP_TICKS(4), .START_LIVES(3)
    ) dut (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Start(start), .i_Abort(abort_in),
        .i_Collision(collision), .i_Frog_At_Top(at_top),
        .o_State(state), .o_Level(level), .o_Lives(lives),
        .o_Reset_Frog(reset_frog), .o_Lane_Step(lane_step),
        .o_Flash(flash), .o_Tick(tick)
    );

    int checks = 0;
    int errors = 0;

    // Event monitor, sampled on the falling edge.
    int   cyc = 0, frog_pulses = 0, flash_toggles = 0;
    int   lane_viol = 0, flash_viol = 0, frog_consec = 0;
    logic frog_prev = 1'b1, flash_prev = 1'b0, rst_prev = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (rst_n === 1'b1) begin
            if (reset_frog && !frog_prev) frog_pulses++;
            if (reset_frog && frog_prev && rst_prev) frog_consec++;
        end
        if (flash !== flash_prev) flash_toggles++;
        if (lane_step != 8'd0 && state != 3'd1) lane_viol++;
        if (flash && state != 3'd2) flash_viol++;
        frog_prev  = reset_frog;
        flash_prev = flash;
        rst_prev   = rst_n;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input string tag);
        int found = 0;
        for (int k = 0; k < 300; k++) begin
            if (state == s) begin
                found = 1;
                break;
            end
            step();
        end
        check(tag, found, 1);
    endtask

    task automatic wait_lane(input int lane, output int at);
        int found = 0;
        at = 0;
        for (int k = 0; k < 200; k++) begin
            step();
            if (lane_step[lane]) begin
                at = cyc;
                found = 1;
                break;
            end
        end
        check("lane_wait", found, 1);
    endtask

    task automatic wait_tick(output int at);
        int found = 0;
        at = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (tick) begin
                at = cyc;
                found = 1;
                break;
            end
        end
        check("tick_wait", found, 1);
    endtask

    task automatic collide();
        collision = 1'b1;
        step();
        collision = 1'b0;
    endtask

    initial begin
        int   a, b, fbase, tbase;
        logic [7:0] lane_or;

        rst_n = 1'b0; start = 1'b0; abort_in = 1'b0; collision = 1'b0; at_top = 1'b0;
        repeat (3) step();
        check("rst_state", state, 0);
        check("rst_level", level, 1);
        check("rst_lives", lives, 3);
        check("rst_frog", reset_frog, 1);
        check("rst_tick", tick, 0);
        check("rst_lane", lane_step, 0);
        check("rst_flash", flash, 0);

        // Release and start a game
        rst_n = 1'b1;
        step();
        check("rel_frog", reset_frog, 0);
        check("rel_state", state, 0);
        wait_tick(a);
        wait_tick(b);
        check("tick_period", b - a, 4);
        fbase = frog_pulses;
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_state", state, 1);
        check("start_level", level, 1);
        check("start_lives", lives, 3);
        check("start_frog", reset_frog, 1);
        step();
        check("start_frog_end", reset_frog, 0);
        check("start_frog_cnt", frog_pulses - fbase, 1);

        wait_lane(0, a);
        wait_lane(0, b);
        check("lane0_period_l1", b - a, 48);
        wait_lane(1, a);
        wait_lane(1, b);
        check("lane1_period_l1", b - a, 36);

        // Collision and top together: collision wins
        tbase = flash_toggles;
        fbase = frog_pulses;
        collision = 1'b1; at_top = 1'b1;
        step();
        collision = 1'b0; at_top = 1'b0;
        check("both_state", state, 2);
        check("both_lives", lives, 2);
        check("both_level", level, 1);
        wait_state(3'd1, "death_return");
        check("death_flash_toggles", flash_toggles - tbase, 8);
        check("death_frog_cnt", frog_pulses - fbase, 1);
        check("death_lives", lives, 2);

        // Run out of lives
        collide();
        check("c2_lives", lives, 1);
        wait_state(3'd1, "c2_return");
        collide();
        check("c3_lives", lives, 0);
        wait_state(3'd4, "game_over_reached");
        check("go_lives", lives, 0);
        lane_or = '0;
        repeat (60) begin
            step();
            lane_or |= lane_step;
        end
        check("go_lane_idle", lane_or, 0);
        check("go_hold_state", state, 4);
        start = 1'b1;
        step();
        start = 1'b0;
        check("go_restart_state", state, 1);
        check("go_restart_level", level, 1);
        check("go_restart_lives", lives, 3);

        // Climb to level 15
        for (int n = 1; n <= 14; n++) begin
            at_top = 1'b1;
            step();
            at_top = 1'b0;
            check("lvlup_state", state, 3);
            check("lvlup_level", level, n + 1);
            wait_state(3'd1, "lvlup_return");
        end
        wait_lane(0, a);
        wait_lane(0, b);
        check("lane0_period_l15", b - a, 8);
        wait_lane(1, a);
        wait_lane(1, b);
        check("lane1_period_l15", b - a, 8);
        at_top = 1'b1;
        step();
        at_top = 1'b0;
        check("lvl15_sat_state", state, 3);
        check("lvl15_sat_level", level, 15);

        // Abort mid level-up
        step();
        step();
        check("pre_abort_state", state, 3);
        fbase = frog_pulses;
        abort_in = 1'b1;
        step();
        abort_in = 1'b0;
        check("abort_state", state, 0);
        check("abort_level", level, 1);
        check("abort_lives", lives, 3);
        check("abort_frog", reset_frog, 1);
        step();
        check("abort_frog_end", reset_frog, 0);
        check("abort_frog_cnt", frog_pulses - fbase, 1);

        // Start held across reset release must not auto-start
        start = 1'b1;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        repeat (5) step();
        check("held_start_idle", state, 0);
        start = 1'b0;
        step();
        check("held_start_low", state, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("held_start_edge", state, 1);

        // Reset mid-play
        repeat (50) step();
        rst_n = 1'b0;
        step();
        check("midrst_state", state, 0);
        check("midrst_frog", reset_frog, 1);
        rst_n = 1'b1;
        step();
        check("post_rst_tick", tick, 0);
        check("post_rst_lane", lane_step, 0);
        check("post_rst_frog", reset_frog, 0);
        check("post_rst_flash", flash, 0);
        check("post_rst_level", level, 1);

        check("lane_outside_play", lane_viol, 0);
        check("flash_outside_dying", flash_viol, 0);
        check("frog_back_to_back", frog_consec, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
